id_ex_pipe: RTL and testbench
=============================

Name: id_ex_pipe

Overview:
- Parametrised ID/EX pipeline stage between decode and the ALU.
- Carries the decoded op, operands, immediate, PC and writeback info, with a valid/ready handshake on both sides.
- An optional one-entry skid buffer breaks the combinational ready path.
- A flush input squashes in-flight instructions on branch redirect or exception.

Parameters:
- XLEN, 32, operand/PC/immediate width
- ALUOP_W, 8, ALU opcode width
- ALUSEL_W, 3, result-select width
- REGADDR_W, 5, destination register address width
- SKID, 1, 1 = registered id_ready plus skid entry; 0 = single register with combinational id_ready

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  squash all held entries and the current input
- id_valid  in  1  decode presents an instruction
- id_ready  out  1  stage can accept this cycle
- id_pc  in  XLEN  instruction PC
- id_aluop  in  ALUOP_W  ALU opcode
- id_alusel  in  ALUSEL_W  result select
- id_reg1  in  XLEN  operand 1
- id_reg2  in  XLEN  operand 2
- id_imm  in  XLEN  immediate
- id_wd  in  REGADDR_W  destination register
- id_wreg  in  1  register write enable
- ex_valid  out  1  EX holds a valid instruction
- ex_ready  in  1  EX consumes this cycle
- ex_pc, ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_imm, ex_wd, ex_wreg  out  same widths as id_*  registered payload

Behaviour:
- Reset (rst=1, asynchronous, independent of clk):
  - ex_valid=0 and skid entry invalid.
  - ex_aluop=EXE_NOP_OP, ex_alusel=EXE_RES_NOP.
  - ex_reg1, ex_reg2, ex_imm, ex_pc = ZeroWord.
  - ex_wd=NOPRegAddr, ex_wreg=WriteDisable.
  - id_ready=0 while rst=1; id_ready=1 on the first cycle after release.
- Bubble rule: whenever ex_valid=0, all ex_* payload holds the NOP/reset values above. EX may ignore ex_valid and still be safe.
- Handshakes:
  - Input accepted when id_valid & id_ready.
  - Output consumed when ex_valid & ex_ready.
  - Payload is stable while ex_valid=1 and ex_ready=0.
- Latency: one cycle from accept to ex_valid with an empty stage. Full throughput, one instruction per cycle, when ex_ready=1 continuously.
- SKID=0:
  - id_ready = ~ex_valid | ex_ready (combinational).
  - Main register loads on accept.
  - If consumed with no new accept, the register loads NOP values and ex_valid goes to 0.
- SKID=1:
  - id_ready = ~skid_valid (registered).
  - Accept while the main register is empty or being consumed: the input goes to the main register.
  - Accept while the main register is held (ex_valid & ~ex_ready): the input goes to the skid entry and id_ready drops next cycle.
  - Consume with skid_valid=1: the skid entry moves to the main register and skid_valid clears. A simultaneous accept is impossible because id_ready=0.
  - Ordering is strictly FIFO; at most 2 instructions in flight.
- Flush (synchronous, highest priority below rst):
  - On the next edge ex_valid=0, skid_valid=0 and the payload becomes NOP values.
  - An input accepted in the same cycle is discarded.
  - A consume in the same cycle is still a valid consume for EX.
  - id_ready follows the normal rule (SKID=1: 1 next cycle).
- Boundary cases:
  - id_valid=0 with the stage idle: payload stays NOP.
  - ex_ready held 0 indefinitely: state holds, no overwrite, id_ready stays 0 once the skid entry is full.
  - rst asserted mid-stall: all state clears immediately, with no clk edge needed.
- No arithmetic; all payload widths are passed through unchanged.

Decomposition:
- Shared defines package: EXE_NOP_OP, EXE_RES_NOP, ZeroWord, NOPRegAddr, WriteDisable, RstEnable, plus the width constants used as parameter defaults.
- One natural sub-module: pipe_slot.
  - One payload register with valid bit, load and clear-to-NOP control.
  - Instantiated twice: main entry, and the skid entry under generate for SKID=1.
- Handshake control logic stays in id_ex_pipe.

Test Plan:
- Reset: assert rst mid-cycle with the stage full -> ex_valid=0, ex_aluop=EXE_NOP_OP and ex_wreg=0 immediately, without a clk edge; id_ready=1 after release.
- Streaming: ex_ready=1, issue PCs 0x0, 0x4, 0x8 on consecutive cycles -> ex_pc 0x0, 0x4, 0x8 one cycle later each, ex_valid continuous.
- Backpressure (SKID=1): ex_ready=0, send PC 0x10 then 0x14 -> id_ready=0 after the second accept, ex_pc holds 0x10. Raise ex_ready -> 0x10 consumed, then 0x14, no loss or duplicate.
- Flush with a full skid entry plus id_valid (PC 0x20) in the same cycle -> next cycle ex_valid=0, ex_wd=0, 0x20 never appears at EX.
- SKID=0 stall: ex_ready=0 with ex_valid=1 -> id_ready=0 combinationally, payload stable (reg1=0xDEADBEEF held) until ex_ready=1.
- Bubble: id_valid=0 for 3 cycles after one instruction is consumed -> ex_valid=0 and payload equal to the NOP values every cycle.

Source files
------------

// File: rtl/id_ex_pipe_pkg.sv
// Shared ID/EX constants: NOP payload encodings, reset polarity and default widths.
// Imported by the interface, the slot register and the stage top.
package id_ex_pipe_pkg;

  localparam int XLEN_DEF      = 32;
  localparam int ALUOP_W_DEF   = 8;
  localparam int ALUSEL_W_DEF  = 3;
  localparam int REGADDR_W_DEF = 5;

  localparam logic RstEnable    = 1'b1;
  localparam logic WriteDisable = 1'b0;

  localparam logic [ALUOP_W_DEF-1:0]   EXE_NOP_OP  = 8'b0000_0000;
  localparam logic [ALUSEL_W_DEF-1:0]  EXE_RES_NOP = 3'b000;
  localparam logic [XLEN_DEF-1:0]      ZeroWord    = 32'h0000_0000;
  localparam logic [REGADDR_W_DEF-1:0] NOPRegAddr  = 5'b00000;

endpackage

// File: rtl/id_ex_pipe_if.sv
// Decoded-instruction stream: valid/ready handshake plus the ID/EX payload fields.
// The master drives valid and payload, the slave drives ready.
interface id_ex_pipe_if
  import id_ex_pipe_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int ALUOP_W   = ALUOP_W_DEF,
  parameter int ALUSEL_W  = ALUSEL_W_DEF,
  parameter int REGADDR_W = REGADDR_W_DEF
);
  logic                 valid;
  logic                 ready;
  logic [XLEN-1:0]      pc;
  logic [ALUOP_W-1:0]   aluop;
  logic [ALUSEL_W-1:0]  alusel;
  logic [XLEN-1:0]      reg1;
  logic [XLEN-1:0]      reg2;
  logic [XLEN-1:0]      imm;
  logic [REGADDR_W-1:0] wd;
  logic                 wreg;

  modport master (output valid, pc, aluop, alusel, reg1, reg2, imm, wd, wreg, input ready);
  modport slave  (input valid, pc, aluop, alusel, reg1, reg2, imm, wd, wreg, output ready);
endinterface

// File: rtl/id_ex_pipe_pipe_slot.sv
// One payload register with valid bit; clear (to NOP) wins over load, otherwise holds.
// Latency one cycle; no handshake of its own, the parent decides load/clear.
module pipe_slot
  import id_ex_pipe_pkg::*;
#(
  parameter int           W       = 1,
  parameter logic [W-1:0] NOP_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clr,
  input  logic [W-1:0] din,
  output logic         vld,
  output logic [W-1:0] dout
);

  logic         vld_q, vld_d;
  logic [W-1:0] dat_q, dat_d;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (clr) begin
      vld_d = 1'b0;
      dat_d = NOP_VAL;
    end else if (load) begin
      vld_d = 1'b1;
      dat_d = din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      vld_q <= 1'b0;
      dat_q <= NOP_VAL;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign vld  = vld_q;
  assign dout = dat_q;

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX stage: one cycle accept-to-EX, full throughput; payload is NOP whenever ex.valid=0.
// SKID=1 gives a flop-driven id ready with a one-entry skid; SKID=0 passes ex ready back combinationally.
module id_ex_pipe
  import id_ex_pipe_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int ALUOP_W   = ALUOP_W_DEF,
  parameter int ALUSEL_W  = ALUSEL_W_DEF,
  parameter int REGADDR_W = REGADDR_W_DEF,
  parameter bit SKID      = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  id_ex_pipe_if.slave   id,
  id_ex_pipe_if.master  ex
);

  typedef struct packed {
    logic [XLEN-1:0]      pc;
    logic [ALUOP_W-1:0]   aluop;
    logic [ALUSEL_W-1:0]  alusel;
    logic [XLEN-1:0]      reg1;
    logic [XLEN-1:0]      reg2;
    logic [XLEN-1:0]      imm;
    logic [REGADDR_W-1:0] wd;
    logic                 wreg;
  } payload_t;

  localparam int PW = $bits(payload_t);
  localparam payload_t NopPayload = '{
    pc:     XLEN'(ZeroWord),
    aluop:  ALUOP_W'(EXE_NOP_OP),
    alusel: ALUSEL_W'(EXE_RES_NOP),
    reg1:   XLEN'(ZeroWord),
    reg2:   XLEN'(ZeroWord),
    imm:    XLEN'(ZeroWord),
    wd:     REGADDR_W'(NOPRegAddr),
    wreg:   WriteDisable
  };

  payload_t id_pay, main_din, main_pay, skid_pay;
  logic     ex_vld, skid_vld, id_rdy;
  logic     accept, consume, main_free;
  logic     main_load, main_clr, skid_load, skid_clr;

  assign id_pay = '{id.pc, id.aluop, id.alusel, id.reg1, id.reg2, id.imm, id.wd, id.wreg};

  assign main_free = ~ex_vld | ex.ready;
  assign consume   = ex_vld & ex.ready;
  assign accept    = id.valid & id_rdy;
  // Held low during reset so decode cannot launch into a clearing stage.
  assign id_rdy    = (rst != RstEnable) & (SKID ? ~skid_vld : main_free);

  always_comb begin
    main_load = 1'b0;
    main_clr  = 1'b0;
    main_din  = id_pay;
    skid_load = 1'b0;
    skid_clr  = 1'b0;
    if (flush) begin
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else if (consume && skid_vld) begin
      main_load = 1'b1;
      main_din  = skid_pay;
      skid_clr  = 1'b1;
    end else if (accept && main_free) begin
      main_load = 1'b1;
    end else if (accept) begin
      skid_load = 1'b1;
    end else if (consume) begin
      main_clr = 1'b1;
    end
  end

  pipe_slot #(.W(PW), .NOP_VAL(NopPayload)) u_main (
    .clk  (clk),
    .rst  (rst),
    .load (main_load),
    .clr  (main_clr),
    .din  (main_din),
    .vld  (ex_vld),
    .dout (main_pay)
  );

  generate
    if (SKID) begin : g_skid
      pipe_slot #(.W(PW), .NOP_VAL(NopPayload)) u_skid (
        .clk  (clk),
        .rst  (rst),
        .load (skid_load),
        .clr  (skid_clr),
        .din  (id_pay),
        .vld  (skid_vld),
        .dout (skid_pay)
      );
    end else begin : g_no_skid
      assign skid_vld = 1'b0;
      assign skid_pay = NopPayload;
    end
  endgenerate

  assign id.ready  = id_rdy;
  assign ex.valid  = ex_vld;
  assign ex.pc     = main_pay.pc;
  assign ex.aluop  = main_pay.aluop;
  assign ex.alusel = main_pay.alusel;
  assign ex.reg1   = main_pay.reg1;
  assign ex.reg2   = main_pay.reg2;
  assign ex.imm    = main_pay.imm;
  assign ex.wd     = main_pay.wd;
  assign ex.wreg   = main_pay.wreg;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Scoreboard bench for id_ex_pipe: SKID=1 (dut a) and SKID=0 (dut b) side by side.
module tb_id_ex_pipe;
  import id_ex_pipe_pkg::*;

  typedef struct packed {
    logic [XLEN_DEF-1:0]      pc;
    logic [ALUOP_W_DEF-1:0]   aluop;
    logic [ALUSEL_W_DEF-1:0]  alusel;
    logic [XLEN_DEF-1:0]      reg1;
    logic [XLEN_DEF-1:0]      reg2;
    logic [XLEN_DEF-1:0]      imm;
    logic [REGADDR_W_DEF-1:0] wd;
    logic                     wreg;
  } pay_t;

  localparam pay_t NOP = '{ZeroWord, EXE_NOP_OP, EXE_RES_NOP, ZeroWord, ZeroWord, ZeroWord,
                           NOPRegAddr, WriteDisable};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  int   checks = 0;
  int   failures = 0;
  pay_t qa[$];
  pay_t qb[$];

  always #5 clk = ~clk;

  id_ex_pipe_if a_id();
  id_ex_pipe_if a_ex();
  id_ex_pipe_if b_id();
  id_ex_pipe_if b_ex();

  id_ex_pipe #(.SKID(1'b1)) u_a (.clk(clk), .rst(rst), .flush(flush), .id(a_id), .ex(a_ex));
  id_ex_pipe #(.SKID(1'b0)) u_b (.clk(clk), .rst(rst), .flush(flush), .id(b_id), .ex(b_ex));

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? qa.size() : qb.size();
  endfunction

  function automatic pay_t qfront(input int d);
    return (d == 0) ? qa[0] : qb[0];
  endfunction

  task automatic qpop(input int d);
    if (d == 0) void'(qa.pop_front()); else void'(qb.pop_front());
  endtask

  task automatic qpush(input int d, input pay_t p);
    if (d == 0) qa.push_back(p); else qb.push_back(p);
  endtask

  task automatic get_dut(input int d, output logic dv, output logic dr, output logic iv,
                         output logic er, output pay_t dp, output pay_t ip);
    if (d == 0) begin
      dv = a_ex.valid; dr = a_id.ready; iv = a_id.valid; er = a_ex.ready;
      dp = '{a_ex.pc, a_ex.aluop, a_ex.alusel, a_ex.reg1, a_ex.reg2, a_ex.imm, a_ex.wd, a_ex.wreg};
      ip = '{a_id.pc, a_id.aluop, a_id.alusel, a_id.reg1, a_id.reg2, a_id.imm, a_id.wd, a_id.wreg};
    end else begin
      dv = b_ex.valid; dr = b_id.ready; iv = b_id.valid; er = b_ex.ready;
      dp = '{b_ex.pc, b_ex.aluop, b_ex.alusel, b_ex.reg1, b_ex.reg2, b_ex.imm, b_ex.wd, b_ex.wreg};
      ip = '{b_id.pc, b_id.aluop, b_id.alusel, b_id.reg1, b_id.reg2, b_id.imm, b_id.wd, b_id.wreg};
    end
  endtask

  task automatic drv(input int d, input logic v, input pay_t p, input logic er);
    if (d == 0) begin
      a_id.valid = v; a_id.pc = p.pc; a_id.aluop = p.aluop; a_id.alusel = p.alusel;
      a_id.reg1 = p.reg1; a_id.reg2 = p.reg2; a_id.imm = p.imm; a_id.wd = p.wd;
      a_id.wreg = p.wreg; a_ex.ready = er;
    end else begin
      b_id.valid = v; b_id.pc = p.pc; b_id.aluop = p.aluop; b_id.alusel = p.alusel;
      b_id.reg1 = p.reg1; b_id.reg2 = p.reg2; b_id.imm = p.imm; b_id.wd = p.wd;
      b_id.wreg = p.wreg; b_ex.ready = er;
    end
  endtask

  function automatic pay_t mk(input logic [31:0] pc);
    pay_t p;
    p.pc = pc;
    p.aluop = ALUOP_W_DEF'($urandom);
    p.alusel = ALUSEL_W_DEF'($urandom);
    p.reg1 = $urandom;
    p.reg2 = $urandom;
    p.imm = $urandom;
    p.wd = REGADDR_W_DEF'($urandom);
    p.wreg = 1'($urandom);
    return p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic er);
    drv(0, 1'b0, NOP, er);
    drv(1, 1'b0, NOP, er);
  endtask

  // Model: an ordered list of accepted instructions; the front is what EX must see.
  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        logic dv, dr, iv, er, rdy_exp;
        pay_t dp, ip;
        int   cnt;
        get_dut(d, dv, dr, iv, er, dp, ip);
        cnt = qsize(d);
        rdy_exp = (d == 0) ? (cnt < 2) : (cnt == 0 || er);
        chk($sformatf("ex_valid[%0d]", d), 160'(dv), 160'(cnt != 0));
        chk($sformatf("payload[%0d]", d), 160'(dp), 160'((cnt != 0) ? qfront(d) : NOP));
        chk($sformatf("id_ready[%0d]", d), 160'(dr), 160'(rdy_exp));
        if (cnt != 0 && er) qpop(d);
        if (flush) begin
          if (d == 0) qa.delete(); else qb.delete();
        end else if (iv && rdy_exp) begin
          qpush(d, ip);
        end
      end
    end
  end

  initial begin
    pay_t p;
    idle(1'b1);
    #2;
    chk("rst_ex_valid_a", 160'(a_ex.valid), 160'(0));
    chk("rst_id_ready_a", 160'(a_id.ready), 160'(0));
    chk("rst_id_ready_b", 160'(b_id.ready), 160'(0));
    chk("rst_aluop_a", 160'(a_ex.aluop), 160'(EXE_NOP_OP));
    step();
    rst = 1'b0;
    #1;
    chk("post_rst_id_ready_a", 160'(a_id.ready), 160'(1));

    for (int i = 0; i < 3; i++) begin
      p = mk(32'(i * 4));
      drv(0, 1'b1, p, 1'b1);
      drv(1, 1'b1, p, 1'b1);
      step();
    end
    idle(1'b1);
    step(); step();

    drv(0, 1'b1, mk(32'h10), 1'b0); step();
    drv(0, 1'b1, mk(32'h14), 1'b0); step();
    drv(0, 1'b0, NOP, 1'b0); step(); step();
    chk("bp_id_ready_a", 160'(a_id.ready), 160'(0));
    chk("bp_hold_pc_a", 160'(a_ex.pc), 160'(32'h10));
    drv(0, 1'b0, NOP, 1'b1); step(); step(); step();

    drv(0, 1'b1, mk(32'h18), 1'b0); step();
    drv(0, 1'b1, mk(32'h1c), 1'b0); step();
    flush = 1'b1;
    drv(0, 1'b1, mk(32'h20), 1'b0); step();
    flush = 1'b0;
    drv(0, 1'b0, NOP, 1'b0);
    chk("flush_ex_valid_a", 160'(a_ex.valid), 160'(0));
    chk("flush_wd_a", 160'(a_ex.wd), 160'(0));
    chk("flush_pc_a", 160'(a_ex.pc), 160'(0));
    drv(0, 1'b0, NOP, 1'b1); step(); step();

    p = mk(32'h30);
    p.reg1 = 32'hDEADBEEF;
    drv(1, 1'b1, p, 1'b0); step();
    drv(1, 1'b1, mk(32'h34), 1'b0);
    #1;
    chk("stall_id_ready_b", 160'(b_id.ready), 160'(0));
    chk("stall_reg1_b", 160'(b_ex.reg1), 160'(32'hDEADBEEF));
    step(); step();
    chk("stall_reg1_hold_b", 160'(b_ex.reg1), 160'(32'hDEADBEEF));
    drv(1, 1'b0, NOP, 1'b1); step();
    idle(1'b1); step(); step(); step();
    chk("bubble_ex_valid_b", 160'(b_ex.valid), 160'(0));

    for (int i = 0; i < 600; i++) begin
      drv(0, ($urandom_range(0, 9) < 7), mk($urandom), ($urandom_range(0, 9) < 6));
      drv(1, ($urandom_range(0, 9) < 7), mk($urandom), ($urandom_range(0, 9) < 6));
      flush = ($urandom_range(0, 19) == 0);
      step();
    end
    flush = 1'b0;

    // Fill both stages, then reset between edges.
    idle(1'b0);
    step(); step();
    drv(0, 1'b1, mk(32'h40), 1'b0);
    drv(1, 1'b1, mk(32'h40), 1'b0);
    step();
    drv(0, 1'b1, mk(32'h44), 1'b0);
    step();
    idle(1'b0);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_ex_valid_a", 160'(a_ex.valid), 160'(0));
    chk("async_rst_aluop_a", 160'(a_ex.aluop), 160'(EXE_NOP_OP));
    chk("async_rst_wreg_a", 160'(a_ex.wreg), 160'(0));
    chk("async_rst_ex_valid_b", 160'(b_ex.valid), 160'(0));
    chk("async_rst_id_ready_a", 160'(a_id.ready), 160'(0));
    qa.delete();
    qb.delete();
    step();
    rst = 1'b0;
    #1;
    chk("rerst_id_ready_a", 160'(a_id.ready), 160'(1));
    chk("rerst_id_ready_b", 160'(b_id.ready), 160'(1));
    for (int i = 0; i < 4; i++) begin
      p = mk(32'(32'h100 + i * 4));
      drv(0, 1'b1, p, 1'b1);
      drv(1, 1'b1, p, 1'b1);
      step();
    end
    idle(1'b1);
    step(); step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
